// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for D-stage hazard detection,
// plus a registered exception-flush FSM and a saturating stall counter.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int CW       = 3,
  parameter int BR_EXTRA = 1,
  parameter int CNTW     = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            dst_valid_d,
  input  logic [AW-1:0]   dst_reg_d,
  input  logic [CW-1:0]   dst_lat_d,
  input  logic            use_a_d,
  input  logic [AW-1:0]   src_a_d,
  input  logic            use_b_d,
  input  logic [AW-1:0]   src_b_d,
  input  logic            early_use_d,
  input  logic            mdu_busy_i,
  input  logic            mem_stall_i,
  input  logic            except_m_i,
  input  logic            clr_cnt_i,
  output logic            stall_f_o,
  output logic            stall_d_o,
  output logic            stall_e_o,
  output logic            stall_m_o,
  output logic            stall_w_o,
  output logic            flush_d_o,
  output logic            flush_e_o,
  output logic            flush_m_o,
  output logic            flush_w_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_PEND = 1'b1;
  localparam int   MAXC   = (2 ** CW) - 1;

  logic [CW-1:0]   r_cnt [NREG];
  logic            r_state;
  logic [CNTW-1:0] r_scnt;

  logic          w_adv;
  logic          w_issue;
  logic          w_flush;
  logic          w_haz;
  logic          w_haz_a;
  logic          w_haz_b;
  logic [CW-1:0] w_cnt_a;
  logic [CW-1:0] w_cnt_b;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_set;

  assign w_adv = !mem_stall_i && !mdu_busy_i;

  assign w_flush = !mem_stall_i &&
                   ((r_state == S_PEND) || except_m_i);

  assign w_cnt_a = r_cnt[src_a_d];
  assign w_cnt_b = r_cnt[src_b_d];

  // D-stage consumers need the value BR_EXTRA cycles sooner
  assign w_haz_a = use_a_d && (src_a_d != '0) &&
                   (early_use_d ? (w_cnt_a != '0)
                                : (w_cnt_a > CW'(BR_EXTRA)));
  assign w_haz_b = use_b_d && (src_b_d != '0) &&
                   (early_use_d ? (w_cnt_b != '0)
                                : (w_cnt_b > CW'(BR_EXTRA)));
  assign w_haz = w_haz_a || w_haz_b;

  assign w_issue = w_adv && !w_haz && !w_flush;

  assign w_sum = {1'b0, dst_lat_d} + (CW+1)'(BR_EXTRA);
  assign w_set = (w_sum > (CW+1)'(MAXC)) ? CW'(MAXC)
                                         : w_sum[CW-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_flush || r == 0)
          r_cnt[r] <= '0;
        else if (w_issue && dst_valid_d &&
                 dst_reg_d == AW'(r))
          r_cnt[r] <= w_set;
        else if (w_adv && r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  // PEND remembers an exception that arrived under a memory stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (except_m_i && mem_stall_i) r_state <= S_PEND;
        S_PEND:
          if (!mem_stall_i) r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_scnt <= '0;
    else if (clr_cnt_i)
      r_scnt <= '0;
    else if (w_haz && !mem_stall_i && r_scnt != '1)
      r_scnt <= r_scnt + 1'b1;
  end

  assign stall_w_o = mem_stall_i;
  assign stall_m_o = mem_stall_i;
  assign stall_e_o = mem_stall_i || mdu_busy_i;
  assign stall_d_o = mem_stall_i || mdu_busy_i || w_haz;
  assign stall_f_o = mem_stall_i ||
                     (!except_m_i && r_state == S_IDLE &&
                      (w_haz || mdu_busy_i));

  assign flush_d_o = w_flush;
  assign flush_e_o = w_flush || (!mem_stall_i && w_haz);
  assign flush_m_o = w_flush || (!mem_stall_i && mdu_busy_i);
  assign flush_w_o = w_flush;

  assign stall_cnt_o = r_scnt;

endmodule
